// File: rtl/msdap_s2p_input.sv
// msdap_s2p_input
//   Stereo serial-to-parallel front end for the MSDAP datapath. Two serial
//   lines (left/right) carry MSB-first words. Each word is aligned by a
//   one-cycle frame pulse. Each completed word pair is presented in parallel
//   with a one-cycle s2p_done pulse. Runs of all-zero pairs are tracked so
//   that Control can decide when to sleep.
//
// Ports
//   clk        in   1       system clock, posedge
//   start      in   1       asynchronous active-high reset
//   frame      in   1       marks the MSB slot of a new word
//   in_l       in   1       left serial data
//   in_r       in   1       right serial data
//   in_ready   in   1       accept frame/bits only while high (otherwise hold)
//   s2p_clear  in   1       synchronous clear, overrides frame and bits
//   data_l     out  WORD_W  last complete left word
//   data_r     out  WORD_W  last complete right word
//   s2p_done   out  1       one-cycle pulse when data_l/data_r update
//   all_zeros  out  1       ZERO_RUN consecutive zero pairs seen
module msdap_s2p_input #(
  parameter int WORD_W   = 16,
  parameter int ZERO_RUN = 800
) (
  input  logic              clk,
  input  logic              start,
  input  logic              frame,
  input  logic              in_l,
  input  logic              in_r,
  input  logic              in_ready,
  input  logic              s2p_clear,
  output logic [WORD_W-1:0] data_l,
  output logic [WORD_W-1:0] data_r,
  output logic              s2p_done,
  output logic              all_zeros
);

  localparam int BC_W = $clog2(WORD_W);
  localparam int ZC_W = $clog2(ZERO_RUN + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [ZC_W-1:0] ZC_MAX   = ZC_W'(ZERO_RUN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  // Only WORD_W-1 bits need storing: the final bit goes straight from the
  // serial input into data_l/data_r on the completing edge.
  logic [WORD_W-2:0] shift_l;
  logic [WORD_W-2:0] shift_r;
  logic [BC_W-1:0]   bit_cnt;
  logic [ZC_W-1:0]   zero_cnt;

  logic [WORD_W-1:0] next_l;
  logic [WORD_W-1:0] next_r;
  logic [ZC_W-1:0]   zero_cnt_next;

  // Saturating increment: the zero-run counter must never wrap back to 0.
  function automatic logic [ZC_W-1:0] sat_inc(input logic [ZC_W-1:0] v);
    return (v == ZC_MAX) ? v : v + ZC_W'(1);
  endfunction

  // Word as it would stand after shifting in the current bits, and the zero
  // run it would produce if this edge completes the word.
  always_comb begin
    next_l        = {shift_l, in_l};
    next_r        = {shift_r, in_r};
    zero_cnt_next = '0;
    if ((next_l == '0) && (next_r == '0))
      zero_cnt_next = sat_inc(zero_cnt);
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state     <= IDLE;
      shift_l   <= '0;
      shift_r   <= '0;
      bit_cnt   <= '0;
      zero_cnt  <= '0;
      data_l    <= '0;
      data_r    <= '0;
      s2p_done  <= 1'b0;
      all_zeros <= 1'b0;
    end else begin
      s2p_done <= 1'b0;
      if (s2p_clear) begin
        state     <= IDLE;
        shift_l   <= '0;
        shift_r   <= '0;
        bit_cnt   <= '0;
        zero_cnt  <= '0;
        data_l    <= '0;
        data_r    <= '0;
        all_zeros <= 1'b0;
      end else if (in_ready) begin
        if (frame) begin
          // A frame always restarts: any partial word (even one at its LSB
          // slot) is dropped and this bit becomes the new MSB.
          state   <= SHIFT;
          shift_l <= {{(WORD_W-2){1'b0}}, in_l};
          shift_r <= {{(WORD_W-2){1'b0}}, in_r};
          bit_cnt <= BC_W'(1);
        end else if (state == SHIFT) begin
          if (bit_cnt == LAST_BIT) begin
            data_l    <= next_l;
            data_r    <= next_r;
            s2p_done  <= 1'b1;
            zero_cnt  <= zero_cnt_next;
            all_zeros <= (zero_cnt_next == ZC_MAX);
            bit_cnt   <= '0;
            state     <= IDLE;
          end else begin
            shift_l <= next_l[WORD_W-2:0];
            shift_r <= next_r[WORD_W-2:0];
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_msdap_s2p_input.sv
// tb_msdap_s2p_input
//   Directed bench for msdap_s2p_input (WORD_W=16, ZERO_RUN=800). Inputs are
//   driven 1 ns after each rising edge; outputs are sampled at that same point.
//   Every expected value is hand-computed from the intended behaviour.
module tb_msdap_s2p_input;

  logic        clk = 1'b0;
  logic        start;
  logic        frame;
  logic        in_l;
  logic        in_r;
  logic        in_ready;
  logic        s2p_clear;
  logic [15:0] data_l;
  logic [15:0] data_r;
  logic        s2p_done;
  logic        all_zeros;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mark;
  int mark_cyc;

  msdap_s2p_input #(.WORD_W(16), .ZERO_RUN(800)) dut (
    .clk(clk), .start(start), .frame(frame), .in_l(in_l), .in_r(in_r),
    .in_ready(in_ready), .s2p_clear(s2p_clear), .data_l(data_l),
    .data_r(data_r), .s2p_done(s2p_done), .all_zeros(all_zeros)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (s2p_done) done_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present bits hi..lo of l/r, one per cycle; frame on the first if asked.
  task automatic send_bits(input logic [15:0] l, input logic [15:0] r,
                           input int hi, input int lo, input bit with_frame);
    for (int i = hi; i >= lo; i--) begin
      frame = with_frame && (i == hi);
      in_l  = l[i];
      in_r  = r[i];
      tick();
    end
    frame = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] l, input logic [15:0] r);
    send_bits(l, r, 15, 0, 1'b1);
  endtask

  initial begin
    start = 1'b1; frame = 1'b0; in_l = 1'b0; in_r = 1'b0;
    in_ready = 1'b1; s2p_clear = 1'b0;
    tick(); tick();
    check("reset_data_l", 32'(data_l), 32'h0);
    check("reset_data_r", 32'(data_r), 32'h0);
    check("reset_done", 32'(s2p_done), 32'h0);
    check("reset_az", 32'(all_zeros), 32'h0);
    start = 1'b0;
    tick();

    // Basic word pair; result visible one cycle after the LSB is presented.
    send_word(16'hA5C3, 16'h0001);
    check("w1_data_l", 32'(data_l), 32'hA5C3);
    check("w1_data_r", 32'(data_r), 32'h0001);
    check("w1_done", 32'(s2p_done), 32'h1);
    check("w1_az", 32'(all_zeros), 32'h0);
    tick();
    check("w1_done_pulse", 32'(s2p_done), 32'h0);
    check("w1_hold_l", 32'(data_l), 32'hA5C3);

    // Asynchronous start mid-word clears outputs at once.
    send_bits(16'hBEEF, 16'hBEEF, 15, 8, 1'b1);
    start = 1'b1;
    #1;
    check("async_data_l", 32'(data_l), 32'h0);
    check("async_data_r", 32'(data_r), 32'h0);
    check("async_done", 32'(s2p_done), 32'h0);
    tick();
    start = 1'b0;
    // Remaining bits of the aborted word without a frame: must not complete.
    mark = done_cnt;
    send_bits(16'hBEEF, 16'hBEEF, 7, 0, 1'b0);
    send_bits(16'hBEEF, 16'hBEEF, 15, 8, 1'b0);
    check("async_no_done", 32'(done_cnt - mark), 32'h0);
    send_word(16'h1111, 16'h2222);
    check("post_rst_done", 32'(s2p_done), 32'h1);
    check("post_rst_l", 32'(data_l), 32'h1111);
    check("post_rst_r", 32'(data_r), 32'h2222);

    // Frame re-asserted at bit 7 of a word: the partial word is dropped.
    mark = done_cnt;
    send_bits(16'hFFFF, 16'hFFFF, 15, 9, 1'b1);
    send_word(16'h1234, 16'h5678);
    check("refrm_done", 32'(s2p_done), 32'h1);
    check("refrm_count", 32'(done_cnt - mark), 32'h1);
    check("refrm_l", 32'(data_l), 32'h1234);
    check("refrm_r", 32'(data_r), 32'h5678);

    // Frame on the LSB slot: no completion, new word starts there.
    mark = done_cnt;
    send_bits(16'hAAAA, 16'hAAAA, 15, 1, 1'b1);
    send_word(16'h0F0F, 16'hF0F0);
    check("lsbfrm_count", 32'(done_cnt - mark), 32'h1);
    check("lsbfrm_l", 32'(data_l), 32'h0F0F);

    // Zero run: 799 pairs not enough, 800th raises, non-zero drops.
    for (int k = 0; k < 799; k++) send_word(16'h0000, 16'h0000);
    check("zr799_az", 32'(all_zeros), 32'h0);
    send_word(16'h0000, 16'h0000);
    check("zr800_az", 32'(all_zeros), 32'h1);
    check("zr800_done", 32'(s2p_done), 32'h1);
    tick();
    check("zr800_hold", 32'(all_zeros), 32'h1);
    send_word(16'h0000, 16'h0001);
    check("zr_nz_az", 32'(all_zeros), 32'h0);
    check("zr_nz_done", 32'(s2p_done), 32'h1);

    // Rebuild the run and go past it: counter saturates, flag stays up.
    for (int k = 0; k < 802; k++) send_word(16'h0000, 16'h0000);
    check("zr_sat_az", 32'(all_zeros), 32'h1);

    // s2p_clear at bit 10 while all_zeros is high.
    mark = done_cnt;
    send_bits(16'h5555, 16'h5555, 15, 6, 1'b1);
    s2p_clear = 1'b1;
    in_l = 1'b1; in_r = 1'b1;
    tick();
    s2p_clear = 1'b0;
    check("clr_az", 32'(all_zeros), 32'h0);
    check("clr_l", 32'(data_l), 32'h0);
    check("clr_r", 32'(data_r), 32'h0);
    send_bits(16'h5555, 16'h5555, 4, 0, 1'b0);
    check("clr_no_done", 32'(done_cnt - mark), 32'h0);
    send_word(16'hFFFF, 16'hFFFF);
    check("clr_next_l", 32'(data_l), 32'hFFFF);
    check("clr_next_r", 32'(data_r), 32'hFFFF);
    check("clr_next_done", 32'(s2p_done), 32'h1);

    // in_ready low for 3 cycles mid-word with a frame pulse inside the stall.
    tick();
    mark = done_cnt;
    mark_cyc = cyc;
    send_bits(16'hC0DE, 16'h3C3C, 15, 11, 1'b1);
    in_ready = 1'b0;
    in_l = 1'b1; in_r = 1'b0;
    tick();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    in_ready = 1'b1;
    send_bits(16'hC0DE, 16'h3C3C, 10, 0, 1'b0);
    check("stall_done", 32'(s2p_done), 32'h1);
    check("stall_count", 32'(done_cnt - mark), 32'h1);
    check("stall_latency", 32'(cyc - mark_cyc), 32'd19);
    check("stall_l", 32'(data_l), 32'hC0DE);
    check("stall_r", 32'(data_r), 32'h3C3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
